// File: rtl/uart_word_receiver.sv
// uart_word_receiver
//   8N1 UART receiver with LSB-first byte deserialisation and little-endian
//   word reassembly. Samples at mid-bit using a CLOCKS_PER_BIT oversampling
//   counter, delivers words over valid/ready, flags framing errors and overruns.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | line idle, waiting for a low level; counts idle-high clocks
//   S_START | qualifying the start bit, sampled at its midpoint
//   S_DATA  | shifting in 8 data bits, one sample per bit time
//   S_STOP  | sampling the stop bit; returns to idle at mid-stop
module uart_word_receiver #(
  parameter int CLOCKS_PER_BIT   = 128,
  parameter int WORD_BYTES       = 4,
  parameter int IDLE_RESYNC_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    uart_rx,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    framing_error,
  output logic                    overrun
);

  localparam int CNT_W    = $clog2(CLOCKS_PER_BIT);
  localparam int IDLE_MAX = IDLE_RESYNC_BITS * CLOCKS_PER_BIT;
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);
  localparam int IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int WORD_W   = 8 * WORD_BYTES;

  localparam logic [CNT_W-1:0]  HALF_M1     = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1     = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDLE_W-1:0] IDLE_TC     = IDLE_W'(IDLE_MAX);
  localparam logic [IDLE_W-1:0] IDLE_TC_M1  = IDLE_W'(IDLE_MAX - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  state_t            r_state;
  logic [CNT_W-1:0]  r_clk_cnt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDX_W-1:0]  r_byte_idx;
  logic [WORD_W-1:0] r_word_buf;
  logic [WORD_W-1:0] r_word_data;
  logic              r_word_valid;
  logic              r_frame_err;
  logic              r_overrun;

  logic              w_rx_s;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_clk_cnt_nxt;
  logic [2:0]        w_bit_cnt_nxt;
  logic [7:0]        w_shift_nxt;
  logic              w_byte_done;
  logic              w_stop_bad;
  logic              w_word_done;
  logic              w_accept;
  logic              w_idle_high;
  logic              w_resync;
  logic [WORD_W-1:0] w_word_asm;

  assign w_rx_s      = r_sync2;
  assign w_word_done = w_byte_done && (r_byte_idx == LAST_IDX);
  assign w_accept    = r_word_valid && word_ready;
  assign w_idle_high = (r_state == S_IDLE) && w_rx_s;
  assign w_resync    = w_idle_high && (r_idle_cnt == IDLE_TC_M1);

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  // FSM and bit-timing registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state logic: mid-bit sampling and stop-bit qualification.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_byte_done   = 1'b0;
    w_stop_bad    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt   = S_START;
          w_clk_cnt_nxt = '0;
        end
      end
      S_START: begin
        if (r_clk_cnt == HALF_M1) begin
          w_clk_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
          // A high level at mid-start is a glitch, not a frame.
          w_state_nxt   = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_clk_cnt == FULL_M1) begin
          w_clk_cnt_nxt          = '0;
          w_shift_nxt[r_bit_cnt] = w_rx_s;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_clk_cnt == FULL_M1) begin
          // Leave at mid-stop so a start bit straight after the stop bit is seen.
          w_clk_cnt_nxt = '0;
          w_state_nxt   = S_IDLE;
          if (w_rx_s) begin
            w_byte_done = 1'b1;
          end else begin
            w_stop_bad = 1'b1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_clk_cnt_nxt = '0;
      end
    endcase
  end

  // Drop the received byte into its lane of the word being assembled.
  always_comb begin
    w_word_asm = r_word_buf;
    w_word_asm[{r_byte_idx, 3'b000} +: 8] = r_shift;
  end

  // Idle-high clock counter; saturates so a long idle never wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idle_cnt <= '0;
    end else if (w_idle_high) begin
      if (r_idle_cnt != IDLE_TC) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end else begin
      r_idle_cnt <= '0;
    end
  end

  // Word assembly: lane index advances per good byte, realigns on errors/idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_byte_idx <= '0;
      r_word_buf <= '0;
    end else if (w_stop_bad) begin
      r_byte_idx <= '0;
    end else if (w_byte_done) begin
      r_word_buf <= w_word_asm;
      r_byte_idx <= (r_byte_idx == LAST_IDX) ? '0 : r_byte_idx + 1'b1;
    end else if (w_resync) begin
      r_byte_idx <= '0;
    end
  end

  // Output handshake: hold a pending word, drop new ones as overruns.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= 1'b0;
      if (w_word_done) begin
        if (!r_word_valid || word_ready) begin
          r_word_data  <= w_word_asm;
          r_word_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_word_valid <= 1'b0;
      end
    end
  end

  assign word_data     = r_word_data;
  assign word_valid    = r_word_valid;
  assign framing_error = r_frame_err;
  assign overrun       = r_overrun;

endmodule
